// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle a - b - bin, one SLICE-bit slice per busy cycle, LSB first.
// Define SEQ_SUB_OVF_EN to compute the signed overflow flag; otherwise ovf is tied to 0.
module seq_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ra, rb;
  logic c, last;
  logic [SLICE:0] sum;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last      = cnt == CW'(N - 1);
  // subtraction as a + ~b + ~bin; the carry chains between slices
  assign sum = {1'b0, ra[cnt*SLICE +: SLICE]} + {1'b0, ~rb[cnt*SLICE +: SLICE]} + {{SLICE{1'b0}}, c};
  always_comb
    state_nx = state == IDLE ? (in_valid ? BUSY : IDLE) :
               state == BUSY ? (last ? DONE : BUSY) :
               (out_ready ? IDLE : DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      ra   <= '0;
      rb   <= '0;
      c    <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra  <= a;
      rb  <= b;
      c   <= ~bin;
      cnt <= '0;
    end else if (state == BUSY) begin
      diff[cnt*SLICE +: SLICE] <= sum[SLICE-1:0];
      c   <= sum[SLICE];
      cnt <= cnt + 1'b1;
      if (last) bout <= ~sum[SLICE];
    end
`ifdef SEQ_SUB_OVF_EN
  // the top result bit is produced by the final slice in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (state == BUSY && last) ovf <= (ra[WIDTH-1] != rb[WIDTH-1]) && (sum[SLICE-1] != ra[WIDTH-1]);
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: randomized and directed checks of seq_subtractor against an arithmetic model.
module tb_seq_subtractor;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, bout, ovf;
  logic [31:0] diff;
  int checks = 0, failures = 0;

  seq_subtractor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic bi);
    logic [32:0] r;
    logic o;
    r = {1'b0, x} - {1'b0, y} - {32'd0, bi};
`ifdef SEQ_SUB_OVF_EN
    o = (x[31] != y[31]) && (r[31] != x[31]);
`else
    o = 1'b0;
`endif
    return {o, r[32], r[31:0]};
  endfunction

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin, output int lat);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, diff, bout, ovf} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b required 1 0 0 0 0", in_ready, out_valid, diff, bout, ovf);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va [6] = '{32'd10, 32'd0, 32'h8000_0000, 32'd5, 32'd5, 32'd100};
    logic [31:0] vb [6] = '{32'd3, 32'd1, 32'd1, 32'd5, 32'd5, 32'd1};
    logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [33:0] e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      e = model(va[i], vb[i], vc[i]);
      run_op(va[i], vb[i], vc[i], lat);
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL directed%0d latency: got %0d required 8", i, lat); end
      checks++;
      if ({ovf, bout, diff} !== e) begin
        failures++;
        $display("FAIL directed%0d result: got ovf=%b bout=%b diff=%h required ovf=%b bout=%b diff=%h", i, ovf, bout, diff, e[33], e[32], e[31:0]);
      end
      finish_op();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        failures++;
        $display("FAIL directed%0d release: in_ready=%b out_valid=%b required 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] e;
    int lat;
    e = model(32'h1234_5678, 32'h0fed_cba9, 1'b1);
    run_op(32'h1234_5678, 32'h0fed_cba9, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; in_valid = i[0];
      checks++;
      if ({out_valid, in_ready, ovf, bout, diff} !== {2'b10, e}) begin
        failures++;
        $display("FAIL hold%0d: out_valid=%b in_ready=%b ovf=%b bout=%b diff=%h required 1 0 %b %b %h", i, out_valid, in_ready, ovf, bout, diff, e[33], e[32], e[31:0]);
      end
    end
    @(negedge clk) in_valid = 1'b0;
    finish_op();
    checks++;
    if ({in_ready, out_valid, ovf, bout, diff} !== {2'b10, e}) begin
      failures++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b ovf=%b bout=%b diff=%h required 1 0 %b %b %h", in_ready, out_valid, ovf, bout, diff, e[33], e[32], e[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    a = 32'hdead_beef; b = 32'h0123_4567; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, diff, bout, ovf} !== {2'b01, 32'd0, 2'b00}) begin
      failures++;
      $display("FAIL midreset: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b required 0 1 0 0 0", out_valid, in_ready, diff, bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1; a = 32'd100; b = 32'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL postreset_accept: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
    checks++;
    if (lat !== 8 || diff !== 32'd99 || bout !== 1'b0) begin
      failures++;
      $display("FAIL postreset_op: lat=%0d diff=%h bout=%b required 8 00000063 0", lat, diff, bout);
    end
    finish_op();
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic bi;
    logic [33:0] e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      x = $urandom; y = (i % 5 == 0) ? x : $urandom; bi = 1'($urandom);
      if (i % 7 == 0) x = {x[31], 31'd0};
      e = model(x, y, bi);
      run_op(x, y, bi, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if (lat !== 8 || {out_valid, ovf, bout, diff} !== {1'b1, e}) begin
        failures++;
        $display("FAIL random%0d a=%h b=%h bin=%b: lat=%0d out_valid=%b ovf=%b bout=%b diff=%h required 8 1 %b %b %h", i, x, y, bi, lat, out_valid, ovf, bout, diff, e[33], e[32], e[31:0]);
      end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_subtractor.md
SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; must be a multiple of SLICE.
REQ-002 SHALL have parameter SLICE, default 4, bits processed per busy cycle.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operands a, b, bin valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  minuend.
REQ-008 SHALL have port b  input  WIDTH  subtrahend.
REQ-009 SHALL have port bin  input  1  borrow in.
REQ-010 SHALL have port out_valid  output  1  diff, bout, ovf valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port diff  output  WIDTH  a - b - bin modulo 2^WIDTH.
REQ-013 SHALL have port bout  output  1  borrow out; 1 when unsigned a < b + bin.
REQ-014 SHALL have port ovf  output  1  signed two's-complement overflow flag.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; IDLE after reset.
REQ-016 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL capture a, b, bin and enter BUSY on the edge where in_valid && in_ready; slice counter cleared.
REQ-018 SHALL in BUSY process one SLICE-bit slice per cycle, LSB slice first: slice_diff = a_slice + ~b_slice + c, where c starts at ~bin and each slice's carry-out feeds the next slice.
REQ-019 SHALL write each slice result into the diff register at the slice position; upper slices are unchanged until processed.
REQ-020 SHALL take exactly WIDTH/SLICE BUSY cycles (8 at default); out_valid rises WIDTH/SLICE cycles after the accepting edge.
REQ-021 SHALL set bout = ~(final carry) on entry to DONE.
REQ-022 SHALL hold diff, bout, ovf stable in DONE until the edge where out_valid && out_ready, then return to IDLE; in_ready is 1 on the following cycle.
REQ-023 SHALL ignore in_valid outside IDLE; there is no overlap of operations.
REQ-024 SHALL leave diff, bout, ovf holding the last result in IDLE.
REQ-025 SHALL treat a == b with bin=0 as diff=0, bout=0; all-ones wrap for 0 - 1 with bout=1.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, slice counter 0, diff 0, bout 0, ovf 0, out_valid 0, in_ready 1 (asynchronously).
REQ-027 SHALL abort any BUSY or DONE operation on reset; no partial result is presented after rst_n is released.
REQ-028 SHALL accept a new operation on the first edge after rst_n release if in_valid=1.

Configuration
REQ-029 SHALL, when macro SEQ_SUB_OVF_EN is defined, set ovf on DONE entry to (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using captured operands.
REQ-030 SHALL, when SEQ_SUB_OVF_EN is undefined, keep port ovf and tie it to 0, with no overflow logic synthesized.

Verification
REQ-031 SHALL cover: a=10, b=3, bin=0 -> diff=7, bout=0, ovf=0, out_valid exactly 8 cycles after accept.
REQ-032 SHALL cover: a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1, ovf=0.
REQ-033 SHALL cover: a=0x80000000, b=1 -> diff=0x7FFFFFFF, bout=0, ovf=1 with SEQ_SUB_OVF_EN, ovf=0 without.
REQ-034 SHALL cover: a=5, b=5, bin=1 -> diff=0xFFFFFFFF, bout=1; a=5, b=5, bin=0 -> diff=0, bout=0.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles in DONE -> diff/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-036 SHALL cover: rst_n pulsed low during 4th BUSY cycle -> out_valid=0, diff=0, in_ready=1 immediately; next op 100-1 -> diff=99 after 8 cycles.
